// File: rtl/lut.sv
// Registered sine/cosine look-up for integer angles in degrees.
// Result is signed Q16.16, produced one cycle after the request edge.
// A 91-entry first-quadrant table is folded to cover the full circle.
// Build option LUT_MOD360_EN: when defined, the whole 32-bit angle is reduced
// modulo 360; when undefined there is no modulo hardware and any angle >= 360
// yields zero.
module lut (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_selector,
  input  logic [31:0] angle,
  output logic [31:0] value
);

  logic [8:0]  a_red;        // angle reduced to 0..359
  logic        force_zero;   // out-of-range angle in the no-modulo build
  logic [9:0]  a_cos;        // angle plus the cosine quarter-turn, pre-wrap
  logic [8:0]  a_prime;      // effective sine angle, 0..359
  logic [6:0]  tab_idx;      // first-quadrant table index, 0..90
  logic        neg;          // result lies in the lower half-plane
  logic [16:0] mag;          // table magnitude, up to 0x10000
  logic [31:0] value_d;
  logic [31:0] value_q;

  // round(sin(k deg) * 65536) for k = 0..90; entry 60 is pinned to 0xDDB3.
  function automatic logic [16:0] sin_rom(input logic [6:0] k);
    case (k)
      7'd0:  sin_rom = 17'd0;
      7'd1:  sin_rom = 17'd1144;
      7'd2:  sin_rom = 17'd2287;
      7'd3:  sin_rom = 17'd3430;
      7'd4:  sin_rom = 17'd4572;
      7'd5:  sin_rom = 17'd5712;
      7'd6:  sin_rom = 17'd6850;
      7'd7:  sin_rom = 17'd7987;
      7'd8:  sin_rom = 17'd9121;
      7'd9:  sin_rom = 17'd10252;
      7'd10: sin_rom = 17'd11380;
      7'd11: sin_rom = 17'd12505;
      7'd12: sin_rom = 17'd13626;
      7'd13: sin_rom = 17'd14742;
      7'd14: sin_rom = 17'd15855;
      7'd15: sin_rom = 17'd16962;
      7'd16: sin_rom = 17'd18064;
      7'd17: sin_rom = 17'd19161;
      7'd18: sin_rom = 17'd20252;
      7'd19: sin_rom = 17'd21336;
      7'd20: sin_rom = 17'd22415;
      7'd21: sin_rom = 17'd23486;
      7'd22: sin_rom = 17'd24550;
      7'd23: sin_rom = 17'd25607;
      7'd24: sin_rom = 17'd26656;
      7'd25: sin_rom = 17'd27697;
      7'd26: sin_rom = 17'd28729;
      7'd27: sin_rom = 17'd29753;
      7'd28: sin_rom = 17'd30767;
      7'd29: sin_rom = 17'd31772;
      7'd30: sin_rom = 17'd32768;
      7'd31: sin_rom = 17'd33754;
      7'd32: sin_rom = 17'd34729;
      7'd33: sin_rom = 17'd35693;
      7'd34: sin_rom = 17'd36647;
      7'd35: sin_rom = 17'd37590;
      7'd36: sin_rom = 17'd38521;
      7'd37: sin_rom = 17'd39441;
      7'd38: sin_rom = 17'd40348;
      7'd39: sin_rom = 17'd41243;
      7'd40: sin_rom = 17'd42126;
      7'd41: sin_rom = 17'd42995;
      7'd42: sin_rom = 17'd43852;
      7'd43: sin_rom = 17'd44695;
      7'd44: sin_rom = 17'd45525;
      7'd45: sin_rom = 17'd46341;
      7'd46: sin_rom = 17'd47143;
      7'd47: sin_rom = 17'd47930;
      7'd48: sin_rom = 17'd48703;
      7'd49: sin_rom = 17'd49461;
      7'd50: sin_rom = 17'd50203;
      7'd51: sin_rom = 17'd50931;
      7'd52: sin_rom = 17'd51643;
      7'd53: sin_rom = 17'd52339;
      7'd54: sin_rom = 17'd53020;
      7'd55: sin_rom = 17'd53684;
      7'd56: sin_rom = 17'd54332;
      7'd57: sin_rom = 17'd54963;
      7'd58: sin_rom = 17'd55578;
      7'd59: sin_rom = 17'd56175;
      7'd60: sin_rom = 17'd56755;
      7'd61: sin_rom = 17'd57319;
      7'd62: sin_rom = 17'd57865;
      7'd63: sin_rom = 17'd58393;
      7'd64: sin_rom = 17'd58903;
      7'd65: sin_rom = 17'd59396;
      7'd66: sin_rom = 17'd59870;
      7'd67: sin_rom = 17'd60326;
      7'd68: sin_rom = 17'd60764;
      7'd69: sin_rom = 17'd61183;
      7'd70: sin_rom = 17'd61584;
      7'd71: sin_rom = 17'd61966;
      7'd72: sin_rom = 17'd62328;
      7'd73: sin_rom = 17'd62672;
      7'd74: sin_rom = 17'd62997;
      7'd75: sin_rom = 17'd63303;
      7'd76: sin_rom = 17'd63589;
      7'd77: sin_rom = 17'd63856;
      7'd78: sin_rom = 17'd64104;
      7'd79: sin_rom = 17'd64332;
      7'd80: sin_rom = 17'd64540;
      7'd81: sin_rom = 17'd64729;
      7'd82: sin_rom = 17'd64898;
      7'd83: sin_rom = 17'd65048;
      7'd84: sin_rom = 17'd65177;
      7'd85: sin_rom = 17'd65287;
      7'd86: sin_rom = 17'd65376;
      7'd87: sin_rom = 17'd65446;
      7'd88: sin_rom = 17'd65496;
      7'd89: sin_rom = 17'd65526;
      7'd90: sin_rom = 17'd65536;
      default: sin_rom = 17'd0;
    endcase
  endfunction

`ifdef LUT_MOD360_EN
  // Byte-wise pre-reduction: 2^8, 2^16, 2^24 are congruent to 256, 16 and
  // 136 mod 360, so the 32-bit angle collapses to a 17-bit sum with the same
  // residue before a narrow final modulo.
  logic [16:0] a_sum;
  assign a_sum = {9'd0, angle[7:0]}
               + {1'b0, angle[15:8], 8'd0}
               + {5'd0, angle[23:16], 4'd0}
               + (17'(angle[31:24]) * 17'd136);
  assign a_red      = 9'(a_sum % 17'd360);
  assign force_zero = 1'b0;
`else
  // No modulo hardware: only 0..359 is meaningful, anything else reads zero.
  assign a_red      = angle[8:0];
  assign force_zero = (angle[31:9] != 23'd0) || (angle[8:0] >= 9'd360);
`endif

  // Cosine is sine advanced by a quarter turn, wrapped back into 0..359.
  always_comb begin
    a_cos   = {1'b0, a_red} + 10'd90;
    a_prime = a_red;
    if (op_selector) begin
      if (a_cos >= 10'd360) begin
        a_cos = a_cos - 10'd360;
      end
      a_prime = a_cos[8:0];
    end
  end

  // Quadrant folding onto the first-quadrant table plus sign selection.
  always_comb begin
    tab_idx = 7'd0;
    neg     = 1'b0;
    if (a_prime <= 9'd90) begin
      tab_idx = 7'(a_prime);
    end else if (a_prime <= 9'd180) begin
      tab_idx = 7'(9'd180 - a_prime);
    end else if (a_prime <= 9'd270) begin
      tab_idx = 7'(a_prime - 9'd180);
      neg     = 1'b1;
    end else begin
      tab_idx = 7'(9'd360 - a_prime);
      neg     = 1'b1;
    end
    mag = sin_rom(tab_idx);
    // Two's-complement negate; a zero magnitude stays zero.
    value_d = neg ? (32'd0 - {15'd0, mag}) : {15'd0, mag};
    if (force_zero) begin
      value_d = 32'd0;
    end
  end

  // Output register; reset wins over a same-edge request.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 32'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: tb/tb_lut.sv
// Self-checking bench for lut: a trigonometric reference model built on $sin
// is compared against the DUT every cycle, plus literal expectations.
module tb_lut;

  logic        clk;
  logic        rst;
  logic        op_selector;
  logic [31:0] angle;
  logic [31:0] value;

  int n_checks = 0;
  int n_bad    = 0;

  logic [31:0] exp_value = 32'd0;
  bit          exp_valid = 1'b0;
  logic        last_rst;
  logic        last_op;
  logic [31:0] last_ang;

  lut dut (
    .clk         (clk),
    .rst         (rst),
    .op_selector (op_selector),
    .angle       (angle),
    .value       (value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: sign and magnitude of the true sine, rounded half away from
  // zero. The 60-degree magnitude is fixed at 0xDDB3 rather than the rounded
  // 56756.
  function automatic logic [31:0] model(input logic op, input logic [31:0] ang);
    int unsigned a;
    real s;
    real m;
    int mag;
`ifdef LUT_MOD360_EN
    a = ang % 32'd360;
`else
    if (ang >= 32'd360) return 32'd0;
    a = ang;
`endif
    if (op) a = (a + 90) % 360;
    s = $sin(real'(a) * 3.14159265358979323846 / 180.0);
    m = (s < 0.0) ? -s : s;
    mag = $rtoi(m * 65536.0 + 0.5);
    if (mag == 56756) mag = 56755;
    return (s < 0.0) ? 32'(-mag) : 32'(mag);
  endfunction

  // Model the registered output from what the DUT samples on each edge.
  always @(posedge clk) begin
    last_rst = rst;
    last_op  = op_selector;
    last_ang = angle;
    if (rst) begin
      exp_value = 32'd0;
      exp_valid = 1'b1;
    end else begin
      exp_value = model(op_selector, angle);
    end
  end

  // Compare every cycle once the output has been defined by a reset.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_checks++;
      if (value !== exp_value) begin
        n_bad++;
        $display("FAIL cycle t=%0t rst=%0b op=%0b angle=%08h value=%08h want=%08h",
                 $time, last_rst, last_op, last_ang, value, exp_value);
      end else begin
        $display("txn t=%0t rst=%0b op=%0b angle=%08h value=%08h",
                 $time, last_rst, last_op, last_ang, value);
      end
    end
  end

  // Apply one request at a falling edge; return at the next falling edge.
  task automatic step(input logic r, input logic op, input logic [31:0] ang);
    rst         = r;
    op_selector = op;
    angle       = ang;
    @(negedge clk);
  endtask

  // One request with a hand-computed expected result; also pins the model.
  task automatic lit(input string name, input logic r, input logic op,
                     input logic [31:0] ang, input logic [31:0] want);
    logic [31:0] m;
    step(r, op, ang);
    n_checks++;
    if (value !== want) begin
      n_bad++;
      $display("FAIL %s: value=%08h want=%08h", name, value, want);
    end
    if (!r) begin
      m = model(op, ang);
      n_checks++;
      if (m !== want) begin
        n_bad++;
        $display("FAIL model_%s: model=%08h want=%08h", name, m, want);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    op_selector = 1'b1;
    angle       = 32'd0;
    @(negedge clk);

    // Reset held, then released with cos 0 pending.
    lit("rst_hold_a", 1'b1, 1'b1, 32'd0, 32'h0000_0000);
    lit("rst_hold_b", 1'b1, 1'b1, 32'd0, 32'h0000_0000);
    lit("rst_release", 1'b0, 1'b1, 32'd0, 32'h0001_0000);

    // Back-to-back sequence.
    lit("sin30", 1'b0, 1'b0, 32'd30, 32'h0000_8000);
    lit("cos30", 1'b0, 1'b1, 32'd30, 32'h0000_DDB3);
    lit("cos60", 1'b0, 1'b1, 32'd60, 32'h0000_8000);
    lit("sin4",  1'b0, 1'b0, 32'd4,  32'h0000_11DC);

    // Quadrants and signs.
    lit("sin180", 1'b0, 1'b0, 32'd180, 32'h0000_0000);
    lit("cos180", 1'b0, 1'b1, 32'd180, 32'hFFFF_0000);
    lit("sin270", 1'b0, 1'b0, 32'd270, 32'hFFFF_0000);
    lit("sin210", 1'b0, 1'b0, 32'd210, 32'hFFFF_8000);
    lit("cos300", 1'b0, 1'b1, 32'd300, 32'h0000_8000);
    lit("sin90",  1'b0, 1'b0, 32'd90,  32'h0001_0000);
    lit("sin15",  1'b0, 1'b0, 32'd15,  32'h0000_4242);

    // Boundaries.
    lit("sin359", 1'b0, 1'b0, 32'd359, 32'hFFFF_FB88);
    lit("cos359", 1'b0, 1'b1, 32'd359, 32'h0000_FFF6);
    lit("sin0",   1'b0, 1'b0, 32'd0,   32'h0000_0000);

`ifdef LUT_MOD360_EN
    lit("sin390", 1'b0, 1'b0, 32'd390, 32'h0000_8000);
    // 0xFFFFFFFF mod 360 is 255, i.e. -T[75] = -63303.
    lit("sin_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_08B9);
    lit("cos_720", 1'b0, 1'b1, 32'd720, 32'h0001_0000);
`else
    lit("sin390", 1'b0, 1'b0, 32'd390, 32'h0000_0000);
    lit("cos390", 1'b0, 1'b1, 32'd390, 32'h0000_0000);
    lit("sin360", 1'b0, 1'b0, 32'd360, 32'h0000_0000);
    lit("sin_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
`endif

    // Reset on the same edge as a request drops it; the stream resumes.
    lit("sin90_pre", 1'b0, 1'b0, 32'd90, 32'h0001_0000);
    lit("rst_drop",  1'b1, 1'b0, 32'd30, 32'h0000_0000);
    lit("after_rst", 1'b0, 1'b1, 32'd90, 32'h0000_0000);

    // Full sweep of both functions over one turn.
    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < 360; a++) begin
        step(1'b0, 1'(op), 32'(a));
      end
    end

    // Random requests with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic        op;
      logic [31:0] ang;
      int          sel;
      r   = ($urandom_range(0, 29) == 0);
      op  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      case (sel)
        0:       ang = 32'($urandom_range(0, 359));
        1:       ang = $urandom;
        2:       ang = 32'($urandom_range(360, 1080));
        default: ang = 32'($urandom_range(0, 3) * 360 + $urandom_range(0, 2));
      endcase
      step(r, op, ang);
    end

    #1;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
